// File: rtl/dct_pkg.sv
// dct_pkg: shared types, sizes and word-slice helper for the 8x8 DCT transpose buffer
package dct_pkg;
    localparam int DCT_N = 8;
    localparam int ROW_IDX_W = 3;
    typedef logic [ROW_IDX_W-1:0] idx_t;
    typedef logic bank_t;
    localparam idx_t LAST_IDX = idx_t'(DCT_N - 1);
    function automatic int word_lsb(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/dct_tbuf_bank.sv
// dct_tbuf_bank: one 8x8 word register array, written a row at a time, read a column at a time
module dct_tbuf_bank
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  idx_t                        row,
    input  logic [DATA_WIDTH*DCT_N-1:0] wdata,
    input  idx_t                        col,
    output logic [DATA_WIDTH*DCT_N-1:0] rdata
);
    logic [DATA_WIDTH*DCT_N-1:0] mem [DCT_N];
    always_ff @(posedge clk) begin
        if (we) mem[row] <= wdata;
    end
    for (genvar k = 0; k < DCT_N; k++) begin : g_col
        assign rdata[word_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = mem[k][word_lsb(int'(col), DATA_WIDTH) +: DATA_WIDTH];
    end
endmodule

// File: rtl/dct_transpose_buf_8x8.sv
// dct_transpose_buf_8x8: ping-pong transpose buffer, rows in, columns out, two banks in flight
module dct_transpose_buf_8x8
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*DCT_N-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*DCT_N-1:0] out_data,
    output logic                        out_last
);
    bank_t wr_bank, rd_bank, wr_bank_n, rd_bank_n;
    idx_t wr_row, rd_col, wr_row_n, rd_col_n;
    logic [1:0] full, full_n;
    logic wr_fire, rd_fire, wr_done, rd_done;
    logic [DATA_WIDTH*DCT_N-1:0] bank_col [2];
    assign in_ready = ~full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_last = out_valid & (rd_col == LAST_IDX);
    assign out_data = out_valid ? bank_col[rd_bank] : '0;
    assign wr_fire = in_valid & in_ready;
    assign rd_fire = out_valid & out_ready;
    assign wr_done = wr_fire & (wr_row == LAST_IDX);
    assign rd_done = rd_fire & (rd_col == LAST_IDX);
    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tbuf_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
            .clk   (clk),
            .we    (wr_fire & (wr_bank == 1'(b))),
            .row   (wr_row),
            .wdata (in_data),
            .col   (rd_col),
            .rdata (bank_col[b])
        );
    end
    always_comb begin
        wr_row_n = wr_fire ? wr_row + 1'b1 : wr_row;
        rd_col_n = rd_fire ? rd_col + 1'b1 : rd_col;
        wr_bank_n = wr_bank ^ wr_done;
        rd_bank_n = rd_bank ^ rd_done;
        full_n = full;
        if (wr_done) full_n[wr_bank] = 1'b1;
        if (rd_done) full_n[rd_bank] = 1'b0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row <= '0;
            rd_col <= '0;
            full <= '0;
        end else begin
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            wr_row <= wr_row_n;
            rd_col <= rd_col_n;
            full <= full_n;
        end
    end
    // a bank can only be finishing a write while it is empty, so it cannot also finish a read
    a_bank_clash: assert property (@(posedge clk) disable iff (!reset_n)
        !(wr_done && rd_done && wr_bank == rd_bank));
endmodule

// File: tb/tb_dct_transpose_buf_8x8.sv
// tb_dct_transpose_buf_8x8: table vectors, directed corner sequences and a queue-based transpose model
module tb_dct_transpose_buf_8x8;
    localparam int DW = 32;
    localparam int BW = DW * 8;

    logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last;
    logic [BW-1:0] in_data = '0;
    logic [BW-1:0] out_data;

    int checks = 0, errors = 0;
    logic [BW-1:0] colq[$];
    logic [DW-1:0] cur[8][8];
    int cur_rows = 0, blk_w = 0, rd_beats = 0;
    bit rnd = 1'b0;

    typedef struct {
        logic iv;
        logic ordy;
        logic ir;
        logic ov;
        logic ol;
        int   col;
    } vec_t;
    vec_t tbl[17];

    always #5 clk = ~clk;

    dct_transpose_buf_8x8 #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pat_row(input int base, input int r);
        logic [BW-1:0] row;
        for (int k = 0; k < 8; k++) row[k*DW +: DW] = base + r * 8 + k;
        return row;
    endfunction

    task automatic model_clear();
        colq.delete();
        cur_rows = 0;
    endtask

    // checks outputs against the model, drives one cycle, then advances the model
    task automatic cyc(input logic iv, input logic ordy);
        logic ir, ov, wf, rf;
        logic [BW-1:0] col;
        ir = colq.size() <= 8;
        ov = colq.size() > 0;
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, ov);
        chk("out_last", out_last, ov && (colq.size() % 8 == 1));
        if (ov) chk("out_data", out_data, colq[0]);
        in_valid = iv;
        out_ready = ordy;
        if (rnd) for (int k = 0; k < 8; k++) in_data[k*DW +: DW] = $urandom();
        else in_data = pat_row(blk_w * 'h100, cur_rows);
        wf = iv && ir;
        rf = ov && ordy;
        @(posedge clk);
        #1;
        if (rf) begin
            void'(colq.pop_front());
            rd_beats++;
        end
        if (wf) begin
            for (int k = 0; k < 8; k++) cur[cur_rows][k] = in_data[k*DW +: DW];
            cur_rows++;
            if (cur_rows == 8) begin
                for (int c = 0; c < 8; c++) begin
                    for (int k = 0; k < 8; k++) col[k*DW +: DW] = cur[k][c];
                    colq.push_back(col);
                end
                cur_rows = 0;
                blk_w++;
            end
        end
    endtask

    task automatic abort(input bit use_rst, input int rows);
        for (int i = 0; i < rows; i++) cyc(1'b1, 1'b0);
        if (use_rst) begin
            in_valid = 1'b0;
            #3 reset_n = 1'b0;
            #1;
            chk("arst_out_valid", out_valid, 1'b0);
            chk("arst_in_ready", in_ready, 1'b1);
            #1 reset_n = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            clear = 1'b1;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
            chk("clr_out_valid", out_valid, 1'b0);
            chk("clr_in_ready", in_ready, 1'b1);
        end
        model_clear();
        for (int i = 0; i < 18; i++) cyc(i < 8, 1'b1);
        chk("abort_fresh_drained", out_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] expc;
        int target, rd0;
        bit done;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, '0);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1};
            tbl[8+i] = '{1'b0, 1'b1, 1'b1, 1'b1, i == 7, i};
        end
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1};
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].ol);
            if (tbl[i].col >= 0) begin
                for (int k = 0; k < 8; k++) expc[k*DW +: DW] = k * 8 + tbl[i].col;
                chk($sformatf("tbl%0d_out_data", i), out_data, expc);
            end
            in_valid = tbl[i].iv;
            in_data = pat_row(0, i);
            out_ready = tbl[i].ordy;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        // three blocks back-to-back; block 1 row 7 and block 0 col 7 finish on the same edge
        for (int i = 0; i < 32; i++) begin
            if (i == 15) begin
                chk("bnd_pre_last", out_last, 1'b1);
                chk("bnd_pre_in_ready", in_ready, 1'b1);
            end
            if (i == 16) begin
                chk("bnd_out_valid", out_valid, 1'b1);
                chk("bnd_out_last", out_last, 1'b0);
                chk("bnd_word0", out_data[DW-1:0], 32'h100);
            end
            cyc(i < 24, 1'b1);
        end

        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_word0", out_data[DW-1:0], 32'h300);
        chk("bp_word7", out_data[7*DW +: DW], 32'h338);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1);
        chk("bp_drained", out_valid, 1'b0);

        abort(1'b0, 5);
        abort(1'b0, 16);
        abort(1'b1, 5);
        abort(1'b1, 16);

        rnd = 1'b1;
        target = blk_w + 100;
        rd0 = rd_beats;
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            cyc(blk_w < target && $urandom_range(1) == 1, $urandom_range(1) == 1);
            done = blk_w == target && colq.size() == 0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL rnd_timeout: got %0d beats expected 800", rd_beats - rd0);
        end
        chk("rnd_drained", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
